// File: rtl/csi_param_pkg.sv
// Lane-count parameter shared by every block of the CSI-2 TX lane path.
package csi_param_pkg;
  localparam int N_DATA_LANES = 4;
endpackage

// File: rtl/csi_typedef_pkg.sv
// Lane-word type and lane-distributor state encoding.
package csi_typedef_pkg;
  import csi_param_pkg::*;

  // Element i is the byte carried on data lane i.
  typedef logic [N_DATA_LANES-1:0][7:0] t_data_lane_bus;

  typedef enum logic [2:0] {IDLE, COLLECT, FLUSH, REQ, DROP} t_lane_dist_state;
endpackage

// File: rtl/csi_lane_distributor_if.sv
// Byte-stream handshake carrying formatted CSI-2 packets into the distributor.
interface csi_lane_distributor_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_sop;
  logic       in_eop;

  modport master (output in_valid, in_data, in_sop, in_eop, input in_ready);
  modport slave  (input in_valid, in_data, in_sop, in_eop, output in_ready);
endinterface

// File: rtl/csi_byte_packer.sv
// Packs accepted bytes into lane words (byte k -> lane k mod N) and holds each
// finished word until the TX FIFO takes it.
module csi_byte_packer
  import csi_param_pkg::*;
  import csi_typedef_pkg::*;
#(
  parameter logic [7:0] FILLER_BYTE = 8'h00,
  parameter int         CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             byte_en_i,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [7:0]       byte_i,
  input  logic             fifo_full_i,
  output logic             fifo_push_o,
  output t_data_lane_bus   fifo_data_o,
  output logic             word_done_o,
  output logic [CNT_W-1:0] word_cnt_o
);
  localparam int                SLOT_W    = (N_DATA_LANES > 1) ? $clog2(N_DATA_LANES) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_DATA_LANES - 1);

  logic [SLOT_W-1:0] slot_q, slot_d;
  t_data_lane_bus    acc_q, acc_d, out_q, out_d, assembled;
  logic              pending_q, pending_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // NOTE: every always_comb target gets a default first so no latch is inferred.
  always_comb begin
    assembled = {N_DATA_LANES{FILLER_BYTE}};
    for (int i = 0; i < N_DATA_LANES; i++) begin
      if (SLOT_W'(i) == slot_q)     assembled[i] = byte_i;
      else if (SLOT_W'(i) < slot_q) assembled[i] = acc_q[i];
    end
  end

  always_comb begin
    slot_d    = slot_q;
    acc_d     = acc_q;
    out_d     = out_q;
    cnt_d     = cnt_q;
    pending_d = pending_q && fifo_full_i;
    if (byte_en_i) begin
      acc_d[slot_q] = byte_i;
      if (start_i) cnt_d = '0;
      // A word closes on the last lane or on the packet's final byte (padded).
      if (slot_q == LAST_SLOT || flush_i) begin
        out_d     = assembled;
        pending_d = 1'b1;
        slot_d    = '0;
        cnt_d     = cnt_d + 1'b1;
      end else begin
        slot_d = slot_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses <= so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q    <= '0;
      acc_q     <= '0;
      out_q     <= '0;
      pending_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      slot_q    <= slot_d;
      acc_q     <= acc_d;
      out_q     <= out_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  assign fifo_push_o = pending_q && !fifo_full_i;
  assign fifo_data_o = out_q;
  assign word_done_o = !(pending_q && fifo_full_i);
  assign word_cnt_o  = cnt_q;
endmodule

// File: rtl/csi_lane_distributor.sv
// CSI-2 TX lane distributor: round-robins packet bytes onto the D-PHY lanes and
// issues one APPI burst request per packet.
module csi_lane_distributor
  import csi_param_pkg::*;
  import csi_typedef_pkg::*;
#(
  parameter int         MAX_BURST_BYTES = 4096,
  parameter logic [7:0] FILLER_BYTE     = 8'h00,
  parameter int         BURST_W         = 16
) (
  input  logic                   hs_tx_word_clk,
  input  logic                   rst_n,
  csi_lane_distributor_if.slave  in_if,
  output logic                   fifo_push,
  output t_data_lane_bus         fifo_data,
  input  logic                   fifo_full,
  output logic                   tx_request_hs,
  output logic [BURST_W-1:0]     burst_size,
  output logic                   err_framing,
  output logic                   err_overflow
);
  localparam logic [BURST_W-1:0] MAX_BYTES = BURST_W'(MAX_BURST_BYTES);

  t_lane_dist_state   state_q, state_d;
  logic [BURST_W-1:0] byte_cnt_q, byte_cnt_d, byte_cnt_next;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               trunc_q, trunc_d;
  logic               run_q;
  logic               err_framing_q, err_framing_d;
  logic               err_overflow_q, err_overflow_d;
  logic               accept, last_byte, byte_en, start, word_done;
  logic [BURST_W-1:0] word_cnt;

  // run_q keeps in_ready low while reset is applied and for the first cycle after.
  assign in_if.in_ready = run_q && !fifo_full && (state_q inside {IDLE, COLLECT, DROP});
  assign accept         = in_if.in_valid && in_if.in_ready;
  assign byte_cnt_next  = (state_q == IDLE) ? BURST_W'(1) : byte_cnt_q + 1'b1;
  assign last_byte      = in_if.in_eop || (byte_cnt_next == MAX_BYTES);

  always_comb begin
    state_d        = state_q;
    byte_cnt_d     = byte_cnt_q;
    burst_d        = burst_q;
    trunc_d        = trunc_q;
    err_framing_d  = 1'b0;
    err_overflow_d = 1'b0;
    byte_en        = 1'b0;
    start          = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        if (in_if.in_sop) begin
          byte_en    = 1'b1;
          start      = 1'b1;
          byte_cnt_d = byte_cnt_next;
          trunc_d    = !in_if.in_eop;
          state_d    = last_byte ? FLUSH : COLLECT;
        end else begin
          err_framing_d = 1'b1;
        end
      end
      COLLECT: if (accept) begin
        byte_en       = 1'b1;
        byte_cnt_d    = byte_cnt_next;
        err_framing_d = in_if.in_sop;
        if (last_byte) begin
          trunc_d = !in_if.in_eop;
          state_d = FLUSH;
        end
      end
      FLUSH: if (word_done) begin
        burst_d = BURST_W'(word_cnt * N_DATA_LANES);
        state_d = REQ;
      end
      REQ: begin
        err_overflow_d = trunc_q;
        state_d        = trunc_q ? DROP : IDLE;
      end
      DROP: if (accept && in_if.in_eop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hs_tx_word_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      byte_cnt_q     <= '0;
      burst_q        <= '0;
      trunc_q        <= 1'b0;
      run_q          <= 1'b0;
      err_framing_q  <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      byte_cnt_q     <= byte_cnt_d;
      burst_q        <= burst_d;
      trunc_q        <= trunc_d;
      run_q          <= 1'b1;
      err_framing_q  <= err_framing_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  csi_byte_packer #(
    .FILLER_BYTE (FILLER_BYTE),
    .CNT_W       (BURST_W)
  ) u_packer (
    .clk         (hs_tx_word_clk),
    .rst_n       (rst_n),
    .byte_en_i   (byte_en),
    .start_i     (start),
    .flush_i     (last_byte),
    .byte_i      (in_if.in_data),
    .fifo_full_i (fifo_full),
    .fifo_push_o (fifo_push),
    .fifo_data_o (fifo_data),
    .word_done_o (word_done),
    .word_cnt_o  (word_cnt)
  );

  assign tx_request_hs = (state_q == REQ);
  assign burst_size    = burst_q;
  assign err_framing   = err_framing_q;
  assign err_overflow  = err_overflow_q;
endmodule

// File: tb/tb_csi_lane_distributor.sv
// Directed bench for csi_lane_distributor: a packet-level model predicts lane
// words and burst sizes; literal expectations pin the model and the timing.
module tb_csi_lane_distributor;
  import csi_param_pkg::*;
  import csi_typedef_pkg::*;

  localparam int         MAX    = 4096;
  localparam logic [7:0] FILLER = 8'h00;

  logic           clk, rst_n, fifo_full;
  logic           fifo_push, tx_request_hs, err_framing, err_overflow;
  t_data_lane_bus fifo_data;
  logic [15:0]    burst_size;

  csi_lane_distributor_if bus();

  csi_lane_distributor #(
    .MAX_BURST_BYTES (MAX),
    .FILLER_BYTE     (FILLER),
    .BURST_W         (16)
  ) dut (
    .hs_tx_word_clk (clk),
    .rst_n          (rst_n),
    .in_if          (bus),
    .fifo_push      (fifo_push),
    .fifo_data      (fifo_data),
    .fifo_full      (fifo_full),
    .tx_request_hs  (tx_request_hs),
    .burst_size     (burst_size),
    .err_framing    (err_framing),
    .err_overflow   (err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;
  int framing_exp = 0, framing_seen = 0, overflow_exp = 0, overflow_seen = 0;
  int first_acc, last_acc, last_ovf_cyc = -1;
  logic [15:0]    last_burst = '0;
  logic [7:0]     pkt_q[$];
  t_data_lane_bus exp_word_q[$], push_log[$];
  logic [15:0]    exp_burst_q[$], req_log[$];
  int             push_cyc_log[$], req_cyc_log[$];
  t_data_lane_bus cmp_word;
  logic [15:0]    cmp_burst;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Packet-level model: the first min(len,MAX) bytes, N per word, lane = index mod N.
  task automatic model_packet(input int len);
    int n     = (len > MAX) ? MAX : len;
    int words = (n + N_DATA_LANES - 1) / N_DATA_LANES;
    for (int w = 0; w < words; w++) begin
      t_data_lane_bus word;
      for (int l = 0; l < N_DATA_LANES; l++)
        word[l] = (w * N_DATA_LANES + l < n) ? pkt_q[w * N_DATA_LANES + l] : FILLER;
      exp_word_q.push_back(word);
    end
    last_burst = 16'(words * N_DATA_LANES);
    exp_burst_q.push_back(last_burst);
    if (len > MAX) overflow_exp++;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (fifo_full) check("ready_while_full", bus.in_ready, 0);
      if (fifo_push) begin
        check("push_while_full", fifo_full, 0);
        check("push_expected", exp_word_q.size() > 0, 1);
        if (exp_word_q.size() > 0) begin
          cmp_word = exp_word_q.pop_front();
          check("fifo_data", fifo_data, cmp_word);
        end
        push_log.push_back(fifo_data);
        push_cyc_log.push_back(cyc);
      end
      if (tx_request_hs) begin
        check("request_expected", exp_burst_q.size() > 0, 1);
        if (exp_burst_q.size() > 0) begin
          cmp_burst = exp_burst_q.pop_front();
          check("burst_size", burst_size, cmp_burst);
        end
        req_log.push_back(burst_size);
        req_cyc_log.push_back(cyc);
      end
      if (err_framing) framing_seen++;
      if (err_overflow) begin
        overflow_seen++;
        last_ovf_cyc = cyc;
      end
    end
  end

  task automatic fill_ramp(input int len, input logic [7:0] start);
    pkt_q.delete();
    for (int i = 0; i < len; i++) pkt_q.push_back(8'(start + i));
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that took the byte.
  task automatic send_byte(input logic [7:0] d, input logic sop, input logic eop, output int acc_cyc);
    bit done = 1'b0;
    acc_cyc = -1;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_sop = sop; bus.in_eop = eop;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc_cyc = cyc;
        done    = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0; bus.in_sop = 1'b0; bus.in_eop = 1'b0;
    check("ready_timeout", done, 1);
  endtask

  task automatic run_packet(input int stall_after, input int stall_len, input int extra_sop);
    int acc;
    model_packet(pkt_q.size());
    if (extra_sop > 0 && extra_sop < pkt_q.size()) framing_exp++;
    for (int i = 0; i < pkt_q.size(); i++) begin
      if (i == stall_after) begin
        fifo_full = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = pkt_q[i]; bus.in_sop = 1'b0; bus.in_eop = 1'b0;
        repeat (stall_len) begin
          @(negedge clk);
          check("stall_in_ready", bus.in_ready, 0);
          check("stall_no_push", fifo_push, 0);
          @(posedge clk); #1;
        end
        fifo_full = 1'b0;
      end
      send_byte(pkt_q[i], (i == 0) || (i == extra_sop), i == pkt_q.size() - 1, acc);
      if (i == 0) first_acc = acc;
      last_acc = acc;
    end
  endtask

  task automatic begin_scenario();
    push_log.delete(); push_cyc_log.delete();
    req_log.delete();  req_cyc_log.delete();
  endtask

  task automatic end_scenario(input string tag);
    repeat (6) @(negedge clk);
    check({tag, "_words_left"}, exp_word_q.size(), 0);
    check({tag, "_requests_left"}, exp_burst_q.size(), 0);
    check({tag, "_framing_pulses"}, framing_seen, framing_exp);
    check({tag, "_overflow_pulses"}, overflow_seen, overflow_exp);
    check({tag, "_burst_hold"}, burst_size, last_burst);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 0);
    check({tag, "_fifo_push"}, fifo_push, 0);
    check({tag, "_fifo_data"}, fifo_data, 0);
    check({tag, "_tx_request_hs"}, tx_request_hs, 0);
    check({tag, "_burst_size"}, burst_size, 0);
    check({tag, "_err_framing"}, err_framing, 0);
    check({tag, "_err_overflow"}, err_overflow, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int eop8, acc;
    rst_n = 1'b0; fifo_full = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_sop = 1'b0; bus.in_eop = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk); #1 rst_n = 1'b1;

    // 8-byte packet followed back-to-back by a 1-byte packet.
    begin_scenario();
    fill_ramp(8, 8'h00); run_packet(-1, 0, -1);
    eop8 = last_acc;
    fill_ramp(1, 8'hAB); run_packet(-1, 0, -1);
    check("b2b_sop_cycle", first_acc, eop8 + 3);
    end_scenario("basic");
    check("basic_push_count", push_log.size(), 3);
    if (push_log.size() == 3) begin
      check("basic_word0", push_log[0], 32'h03020100);
      check("basic_word1", push_log[1], 32'h07060504);
      check("one_byte_word", push_log[2], 32'h000000AB);
      check("basic_push_latency", push_cyc_log[1], eop8 + 1);
      check("one_byte_push_latency", push_cyc_log[2], last_acc + 1);
    end
    check("basic_req_count", req_log.size(), 2);
    if (req_log.size() == 2) begin
      check("basic_burst", req_log[0], 8);
      check("one_byte_burst", req_log[1], 4);
      check("basic_req_latency", req_cyc_log[0], eop8 + 2);
      check("one_byte_req_latency", req_cyc_log[1], last_acc + 2);
    end

    // 6-byte packet with the FIFO full for 5 cycles after the first word.
    begin_scenario();
    fill_ramp(6, 8'h00); run_packet(4, 5, -1);
    end_scenario("stall");
    check("stall_push_count", push_log.size(), 2);
    if (push_log.size() == 2) begin
      check("stall_word0", push_log[0], 32'h03020100);
      check("stall_word1", push_log[1], 32'h00000504);
    end
    check("stall_req_count", req_log.size(), 1);
    if (req_log.size() == 1) check("stall_burst", req_log[0], 8);

    // Stray byte in IDLE, then a clean packet and one with a sop mid-packet.
    begin_scenario();
    send_byte(8'h55, 1'b0, 1'b0, acc);
    framing_exp++;
    fill_ramp(4, 8'h10); run_packet(-1, 0, -1);
    fill_ramp(4, 8'h20); run_packet(-1, 0, 2);
    end_scenario("framing");
    check("framing_push_count", push_log.size(), 2);
    if (push_log.size() == 2) begin
      check("framing_word0", push_log[0], 32'h13121110);
      check("framing_word1", push_log[1], 32'h23222120);
    end
    check("framing_req_count", req_log.size(), 2);
    if (req_log.size() == 2) check("framing_burst", req_log[0], 4);

    // Oversized packet: truncated at MAX, tail dropped.
    begin_scenario();
    fill_ramp(4100, 8'h00); run_packet(-1, 0, -1);
    end_scenario("overflow");
    check("overflow_push_count", push_log.size(), 1024);
    if (push_log.size() == 1024) check("overflow_last_word", push_log[1023], 32'hFFFEFDFC);
    check("overflow_req_count", req_log.size(), 1);
    if (req_log.size() == 1) begin
      check("overflow_burst", req_log[0], 4096);
      check("overflow_pulse_cycle", last_ovf_cyc, req_cyc_log[0] + 1);
    end

    begin_scenario();
    fill_ramp(4, 8'h30); run_packet(-1, 0, -1);
    end_scenario("after_overflow");
    check("after_overflow_push_count", push_log.size(), 1);
    if (push_log.size() == 1) check("after_overflow_word", push_log[0], 32'h33323130);

    // Reset after 3 bytes of a packet: nothing emitted, next packet starts at lane 0.
    begin_scenario();
    send_byte(8'hC0, 1'b1, 1'b0, acc);
    send_byte(8'hC1, 1'b0, 1'b0, acc);
    send_byte(8'hC2, 1'b0, 1'b0, acc);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    fill_ramp(4, 8'hA0); run_packet(-1, 0, -1);
    end_scenario("reset");
    check("reset_push_count", push_log.size(), 1);
    if (push_log.size() == 1) check("reset_word", push_log[0], 32'hA3A2A1A0);
    check("reset_req_count", req_log.size(), 1);
    if (req_log.size() == 1) check("reset_burst", req_log[0], 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/csi_lane_distributor.md
Name: csi_lane_distributor

Overview:
- Synthesizable CSI-2 TX lane-management stage, directly upstream of the D-PHY master adapter layer.
- Accepts a byte stream of complete CSI-2 packets, already header/ECC/CRC-formatted, with valid/ready handshake.
- Distributes bytes round-robin across N_DATA_LANES: byte k goes to lane k mod N_DATA_LANES.
- Pushes one lane word per cycle into the adapter's TX FIFO, then issues one APPI burst request per packet with the padded burst size.

Parameters:
- N_DATA_LANES, 4, number of data lanes; bytes per FIFO word.
- MAX_BURST_BYTES, 4096, largest burst in bytes; must be a multiple of N_DATA_LANES.
- FILLER_BYTE, 8'h00, pad value for unused lane slots of the last word.
- BURST_W, 16, width of burst_size.

Ports:
- hs_tx_word_clk  in  1  HS TX word clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input byte valid.
- in_ready  out  1  input byte accepted when in_valid & in_ready.
- in_data  in  8  packet byte.
- in_sop  in  1  first byte of packet.
- in_eop  in  1  last byte of packet; sop & eop together means a 1-byte packet.
- fifo_push  out  1  write fifo_data into TX FIFO.
- fifo_data  out  N_DATA_LANES*8  lane word; byte i is lane i.
- fifo_full  in  1  TX FIFO cannot accept a push this cycle.
- tx_request_hs  out  1  one-cycle burst request pulse, drives APPI TxRequestHS.
- burst_size  out  BURST_W  burst length in bytes, drives APPI BurstSize.
- err_framing  out  1  one-cycle pulse on protocol violation.
- err_overflow  out  1  one-cycle pulse when a packet exceeds MAX_BURST_BYTES.

Behaviour:
- Reset (async, rst_n=0): state IDLE. in_ready=0, fifo_push=0, fifo_data=0, tx_request_hs=0, burst_size=0, err_*=0. Partial word and byte/word counters cleared.
- Reset mid-packet: the partial word is discarded; no push or request is produced.
- in_ready = !fifo_full in IDLE, COLLECT and DROP. in_ready = 0 in FLUSH and REQ. in_ready depends only on registered state and fifo_full, never on in_valid/in_sop/in_eop.
- States:
  - IDLE: accepted byte with in_sop → slot 0, go to COLLECT (or FLUSH if in_eop as well). Accepted byte without sop → dropped, err_framing pulse.
  - COLLECT: each accepted byte fills the next slot. When slot N_DATA_LANES-1 fills, fifo_push=1 on the next cycle with the full word and word_cnt++.
    - in_eop → FLUSH.
    - in_sop in COLLECT → err_framing pulse; the byte is treated as ordinary data.
    - Byte count reaching MAX_BURST_BYTES without eop → FLUSH, then DROP.
  - FLUSH (1 cycle): if a partial word remains, fill the unused slots with FILLER_BYTE and push it. Wait while fifo_full (push held, fifo_data stable). Then go to REQ.
  - REQ (1 cycle): tx_request_hs=1; burst_size = word_cnt*N_DATA_LANES, registered and held until the next REQ. Then IDLE, or DROP if truncated.
  - DROP: accepts and discards bytes up to and including eop. err_overflow pulses once on entry. eop → IDLE.
- Latency: last byte accepted at cycle t → final fifo_push at t+1 (when the FIFO is not full) → tx_request_hs at t+2.
- Back-to-back packets: IDLE accepts a new sop at t+3.
- burst_size is always a nonzero multiple of N_DATA_LANES and ≤ MAX_BURST_BYTES.
- fifo_push is never asserted while fifo_full=1. A pending push holds fifo_data until it completes.
- Exactly one tx_request_hs pulse per packet, including truncated packets.

Decomposition:
- Shared packages:
  - N_DATA_LANES goes in csi_param_pkg.
  - The lane-word type (t_data_lane_bus) and the state enum (t_lane_dist_state: IDLE, COLLECT, FLUSH, REQ, DROP) go in csi_typedef_pkg.
- One sub-module, csi_byte_packer:
  - Holds the slot index, the word register and the pad/flush logic.
  - Outputs word_done and word_cnt.
  - The parent keeps the FSM, the request and the error logic.

Test Plan:
- 8-byte packet 00..07, N=4, no stall → pushes 0x03020100 then 0x07060504 (lane0=LSB). One tx_request_hs pulse with burst_size=8, two cycles after the eop byte.
- 1-byte packet (sop & eop, 0xAB) → single push 0x000000AB, burst_size=4.
- 6-byte packet with fifo_full held high for 5 cycles mid-packet → in_ready=0 during the stall. No push while full. Word order intact; final word 0x00000504 padded; burst_size=8.
- Byte without sop in IDLE → err_framing pulse, no push, no request. A following valid 4-byte packet gives burst_size=4.
- 4100-byte packet, MAX=4096 → 1024 pushes, burst_size=4096, err_overflow pulse. Remaining 4 bytes discarded; the next packet proceeds normally.
- rst_n low for 1 cycle after 3 bytes of a packet → all outputs at reset values. No push, no request for that packet. The next packet starts at lane 0.
